// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: decodes a strided channel window, checks per-channel
// read/write permission and runs a registered select/ack handshake with a timeout.
module io_bus_ctrl #(
  parameter int              N_CH        = 4,
  parameter logic [31:0]     BASE        = 32'h1001_0000,
  parameter int              STRIDE_LOG2 = 4,
  parameter logic [N_CH-1:0] CH_WR       = 4'b1101,
  parameter logic [N_CH-1:0] CH_RD       = 4'b1110,
  parameter int              TIMEOUT     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic                 cs,
  input  logic                 sig_w,
  input  logic                 sig_r,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic                 err,
  output logic [N_CH-1:0]      dev_cs,
  output logic                 dev_we,
  output logic                 dev_re,
  output logic [31:0]          dev_wdata,
  input  logic [32*N_CH-1:0]   dev_rdata,
  input  logic [N_CH-1:0]      dev_ack
);

  localparam int          CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [31:0] SPAN       = 32'(N_CH) << STRIDE_LOG2;
  localparam logic [31:0] ALIGN_MASK = (32'd1 << STRIDE_LOG2) - 32'd1;
  localparam logic [7:0]  TO_LIM     = 8'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]      state;
  logic [CH_W-1:0] ch_q;
  logic [7:0]      cnt;

  logic [31:0]     off;
  logic            hit;
  logic            allowed;
  logic            req;
  logic            legal;
  logic [CH_W-1:0] ch_dec;
  logic [31:0]     dev_rd_arr [N_CH];

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [N_CH-1:0] oh;
    for (int i = 0; i < N_CH; i++) begin
      oh[i] = (c == CH_W'(i));
    end
    return oh;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign dev_rd_arr[g] = dev_rdata[32*g +: 32];
  end

  // Addresses below BASE wrap to a huge offset and fall outside SPAN.
  always_comb begin
    off     = addr - BASE;
    hit     = (off < SPAN) && ((off & ALIGN_MASK) == 32'd0);
    ch_dec  = CH_W'(off >> STRIDE_LOG2);
    allowed = hit && (sig_w ? CH_WR[ch_dec] : CH_RD[ch_dec]);
    req     = cs && (sig_w || sig_r);
    legal   = req && !(sig_w && sig_r) && allowed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ch_q      <= '0;
      cnt       <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      dev_cs    <= '0;
      dev_we    <= 1'b0;
      dev_re    <= 1'b0;
      dev_wdata <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (legal) begin
            state     <= ST_ACCESS;
            ch_q      <= ch_dec;
            cnt       <= '0;
            dev_cs    <= onehot(ch_dec);
            dev_we    <= sig_w;
            dev_re    <= sig_r;
            dev_wdata <= wdata;
          end else if (req) begin
            state <= ST_DONE;
            ready <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
          end
        end
        ST_ACCESS: begin
          // Ack is tested before the limit so an ack on the final count wins.
          if (dev_ack[ch_q]) begin
            state  <= ST_DONE;
            ready  <= 1'b1;
            err    <= 1'b0;
            rdata  <= dev_re ? dev_rd_arr[ch_q] : '0;
            dev_cs <= '0;
            dev_we <= 1'b0;
            dev_re <= 1'b0;
          end else if (cnt == TO_LIM) begin
            state  <= ST_DONE;
            ready  <= 1'b1;
            err    <= 1'b1;
            rdata  <= '0;
            dev_cs <= '0;
            dev_we <= 1'b0;
            dev_re <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: directed vector table, hand-written multi-cycle sequences
// and randomized transactions checked against a transaction-level reference model.
module tb_io_bus_ctrl;

  localparam int          N_CH        = 4;
  localparam logic [31:0] BASE        = 32'h1001_0000;
  localparam int          STRIDE_LOG2 = 4;
  localparam logic [3:0]  CH_WR       = 4'b1101;
  localparam logic [3:0]  CH_RD       = 4'b1110;
  localparam int          TIMEOUT     = 15;
  localparam int          NEVER       = 1000;

  logic                clk;
  logic                rst_n;
  logic [31:0]         addr;
  logic                cs;
  logic                sig_w;
  logic                sig_r;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic                ready;
  logic                err;
  logic [N_CH-1:0]     dev_cs;
  logic                dev_we;
  logic                dev_re;
  logic [31:0]         dev_wdata;
  logic [32*N_CH-1:0]  dev_rdata;
  logic [N_CH-1:0]     dev_ack;

  io_bus_ctrl #(
    .N_CH(N_CH), .BASE(BASE), .STRIDE_LOG2(STRIDE_LOG2),
    .CH_WR(CH_WR), .CH_RD(CH_RD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .cs(cs), .sig_w(sig_w), .sig_r(sig_r),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .dev_cs(dev_cs),
    .dev_we(dev_we), .dev_re(dev_re), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic        r;
    logic [31:0] wdata;
    int          ch;
    int          dly;
    logic [31:0] rd;
    logic [3:0]  stray;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cs;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] v;
    v = 4'b0000;
    if (c >= 0 && c < N_CH) v[c] = 1'b1;
    return v;
  endfunction

  // Reference: a transaction is legal iff the address equals some channel's slot
  // exactly, exactly one strobe is set and that channel permits the direction.
  task automatic model(input logic [31:0] a, input logic w, input logic r, input int dly,
                       input logic [31:0] rdv, output int ch, output int lat,
                       output logic e, output logic [31:0] rd, output int csn);
    logic legal;
    ch = -1;
    for (int i = 0; i < N_CH; i++)
      if (a == BASE + 32'(i) * (32'd1 << STRIDE_LOG2)) ch = i;
    legal = 1'b0;
    if (ch >= 0 && w != r) legal = w ? CH_WR[ch] : CH_RD[ch];
    if (!legal) begin
      lat = 1; e = 1'b1; rd = '0; csn = 0;
    end else if (dly <= TIMEOUT) begin
      lat = dly + 2; e = 1'b0; rd = r ? rdv : 32'h0; csn = dly + 1;
    end else begin
      lat = TIMEOUT + 2; e = 1'b1; rd = '0; csn = TIMEOUT + 1;
    end
  endtask

  task automatic run_txn(input vec_t v, output int lat, output logic e, output logic [31:0] rd,
                         output int cs_n, output int bad, output int rcyc);
    lat = -1; e = 1'bx; rd = 'x; cs_n = 0; bad = 0; rcyc = -1;
    @(negedge clk);
    chk("idle_ready_low", 32'(ready), 32'h0);
    cs = 1'b1; addr = v.addr; sig_w = v.w; sig_r = v.r; wdata = v.wdata; dev_ack = '0;
    for (int i = 0; i < N_CH; i++) dev_rdata[32*i +: 32] = (i == v.ch) ? v.rd : $urandom;
    @(posedge clk);
    #1;
    cs = 1'b0; addr = $urandom; sig_w = 1'($urandom); sig_r = 1'($urandom); wdata = $urandom;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (dev_cs != '0) begin
        cs_n++;
        if (dev_cs !== oh(v.ch) || dev_we !== v.w || dev_re !== v.r || dev_wdata !== v.wdata)
          bad++;
      end
      if (ready === 1'b1) begin
        lat = k; e = err; rd = rdata; rcyc = cyc;
        if (dev_cs != '0 || dev_we || dev_re) bad++;
        break;
      end
      dev_ack = v.stray | ((k == 1 + v.dly) ? oh(v.ch) : 4'b0000);
      for (int i = 0; i < N_CH; i++) if (i != v.ch) dev_rdata[32*i +: 32] = $urandom;
    end
    dev_ack = '0;
  endtask

  task automatic run_chk(input vec_t v, input string tag, output int rcyc);
    int lat, cs_n, bad;
    logic e;
    logic [31:0] rd;
    run_txn(v, lat, e, rd, cs_n, bad, rcyc);
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("%s_err", tag), 32'(e), 32'(v.exp_err));
    chk($sformatf("%s_rdata", tag), rd, v.exp_rdata);
    chk($sformatf("%s_cs_cycles", tag), 32'(cs_n), 32'(v.exp_cs));
    chk($sformatf("%s_sel_bad", tag), 32'(bad), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s_rdata", tag), rdata, 32'h0);
    chk($sformatf("%s_ready", tag), 32'(ready), 32'h0);
    chk($sformatf("%s_err", tag), 32'(err), 32'h0);
    chk($sformatf("%s_dev_cs", tag), 32'(dev_cs), 32'h0);
    chk($sformatf("%s_dev_we", tag), 32'(dev_we), 32'h0);
    chk($sformatf("%s_dev_re", tag), 32'(dev_re), 32'h0);
    chk($sformatf("%s_dev_wdata", tag), dev_wdata, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r1, r2, rc, nrdy;
    vec_t v;
    //         addr           w     r     wdata         ch  dly    rd            stray    lat err   rdata         cs
    tbl[0]  = '{32'h10010000, 1'b1, 1'b0, 32'h12345678, 0,  0,     32'h0,        4'b0000, 2,  1'b0, 32'h0,        1};
    tbl[1]  = '{32'h10010010, 1'b0, 1'b1, 32'h0,        1,  2,     32'h000000A5, 4'b0100, 4,  1'b0, 32'h000000A5, 3};
    tbl[2]  = '{32'h10010000, 1'b0, 1'b1, 32'h0,        0,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[3]  = '{32'h10010010, 1'b1, 1'b0, 32'h11110000, 1,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[4]  = '{32'h10010044, 1'b0, 1'b1, 32'h0,        0,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[5]  = '{32'h10010004, 1'b0, 1'b1, 32'h0,        0,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[6]  = '{32'h10010020, 1'b1, 1'b0, 32'hAAAA5555, 2,  NEVER, 32'h0,        4'b1000, 17, 1'b1, 32'h0,        16};
    tbl[7]  = '{32'h10010020, 1'b1, 1'b0, 32'h5555AAAA, 2,  15,    32'h0,        4'b1000, 17, 1'b0, 32'h0,        16};
    tbl[8]  = '{32'h10010030, 1'b0, 1'b1, 32'h0,        3,  0,     32'hDEADBEEF, 4'b0001, 2,  1'b0, 32'hDEADBEEF, 1};
    tbl[9]  = '{32'h1000FFF0, 1'b0, 1'b1, 32'h0,        0,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[10] = '{32'h10010030, 1'b1, 1'b1, 32'h0,        3,  0,     32'h0,        4'b0000, 1,  1'b1, 32'h0,        0};
    tbl[11] = '{32'h10010020, 1'b0, 1'b1, 32'h0,        2,  5,     32'h00005A5A, 4'b0011, 7,  1'b0, 32'h00005A5A, 6};

    rst_n = 1'b0; cs = 1'b0; addr = '0; sig_w = 1'b0; sig_r = 1'b0; wdata = '0;
    dev_rdata = '0; dev_ack = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");

    for (int i = 0; i < 12; i++) run_chk(tbl[i], $sformatf("vec%0d", i), rc);

    // cs with no strobe is not a request
    @(negedge clk);
    cs = 1'b1; addr = 32'h10010030; sig_w = 1'b0; sig_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("nostrobe_ready_%0d", k), 32'(ready), 32'h0);
      chk($sformatf("nostrobe_dev_cs_%0d", k), 32'(dev_cs), 32'h0);
    end
    cs = 1'b0;

    // back-to-back: read ch3 then write ch2
    v = '{32'h10010030, 1'b0, 1'b1, 32'h0, 3, 0, 32'h33330003, 4'b0000, 2, 1'b0, 32'h33330003, 1};
    run_chk(v, "b2b_rd3", r1);
    v = '{32'h10010020, 1'b1, 1'b0, 32'h0BADF00D, 2, 0, 32'h0, 4'b0000, 2, 1'b0, 32'h0, 1};
    run_chk(v, "b2b_wr2", r2);
    chk("b2b_ready_gap", 32'(r2 - r1), 32'd3);

    // reset during a pending ch1 read
    v = '{32'h10010010, 1'b0, 1'b1, 32'h0, 1, 0, 32'hA5A50001, 4'b0000, 2, 1'b0, 32'hA5A50001, 1};
    run_chk(v, "pre_rst_rd1", rc);
    @(negedge clk);
    cs = 1'b1; addr = 32'h10010010; sig_w = 1'b0; sig_r = 1'b1; wdata = 32'hCAFEF00D; dev_ack = '0;
    @(posedge clk);
    #1 cs = 1'b0; sig_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pending_dev_cs", 32'(dev_cs), 32'h2);
    chk("rst_pending_dev_wdata", dev_wdata, 32'hCAFEF00D);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    nrdy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready === 1'b1 || dev_cs != '0) nrdy++;
    end
    chk("midrst_no_ready", 32'(nrdy), 32'h0);
    v = '{32'h10010010, 1'b0, 1'b1, 32'h0, 1, 1, 32'h0000C0DE, 4'b1001, 3, 1'b0, 32'h0000C0DE, 2};
    run_chk(v, "post_rst_rd1", rc);

    // randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      int sel, c, s;
      sel = $urandom_range(0, 9);
      c   = $urandom_range(0, N_CH - 1);
      case (sel)
        6:       v.addr = BASE + 32'(c << STRIDE_LOG2) + 32'($urandom_range(1, 15));
        7:       v.addr = BASE + 32'((N_CH + $urandom_range(0, 3)) << STRIDE_LOG2);
        8:       v.addr = BASE - 32'($urandom_range(1, 64));
        9:       v.addr = $urandom;
        default: v.addr = BASE + 32'(c << STRIDE_LOG2);
      endcase
      s = $urandom_range(0, 5);
      v.w = (s <= 2) || (s == 5);
      v.r = (s >= 3);
      v.wdata = $urandom;
      v.rd    = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       v.dly = TIMEOUT;
          1:       v.dly = TIMEOUT + 1;
          default: v.dly = NEVER;
        endcase
      end else begin
        v.dly = $urandom_range(0, 6);
      end
      model(v.addr, v.w, v.r, v.dly, v.rd, v.ch, v.exp_lat, v.exp_err, v.exp_rdata, v.exp_cs);
      v.stray = 4'($urandom) & ~oh(v.ch);
      run_chk(v, $sformatf("rnd%0d", n), rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
